// File: rtl/micadc_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : micadc_capture_if                                            |
// | Description : Bundle of the microphone ADC capture signals: the control    |
// |               and sample-stream side toward the transmitter and the SPI    |
// |               pins toward the ADC.                                         |
// |               master : the capture block (drives CS/SCK and the sample).   |
// |               slave  : the environment (request/enable and ADC data).      |
// | Signals     : i_en, i_request, i_miso       (toward the capture block)     |
// |               o_csn, o_sck, o_busy, o_valid, o_data[11:0], o_frame_err,    |
// |               o_overrun                     (from the capture block)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface micadc_capture_if;
   logic        i_en;
   logic        i_request;
   logic        i_miso;
   logic        o_csn;
   logic        o_sck;
   logic        o_busy;
   logic        o_valid;
   logic [11:0] o_data;
   logic        o_frame_err;
   logic        o_overrun;

   modport master (
      input  i_en, i_request, i_miso,
      output o_csn, o_sck, o_busy, o_valid, o_data, o_frame_err, o_overrun
   );

   modport slave (
      output i_en, i_request, i_miso,
      input  o_csn, o_sck, o_busy, o_valid, o_data, o_frame_err, o_overrun
   );
endinterface
`default_nettype wire

// File: rtl/micadc_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : micadc_capture                                               |
// | Description : SPI capture front end for the 12-bit microphone ADC. Each    |
// |               sample request runs one 16-bit SPI frame (CS low, SCK idles  |
// |               high, data sampled on the SCK rising edge) and returns a     |
// |               signed 12-bit sample with a one-cycle valid strobe.          |
// | Ports       : i_clk      - system clock                                    |
// |               i_reset_n  - asynchronous active-low reset                   |
// |               bus        - micadc_capture_if.master (enable, request,      |
// |                            SPI pins, sample/valid/status outputs)          |
// | Parameters  : CKPCK - system clocks per SCK half-period (>= 1)             |
// |               LGDC  - DC-blocker time-constant shift (>= 1)                |
// | Options     : MICADC_DCBLOCK_EN - when defined, a leaky DC blocker sits    |
// |               on the sample path and valid is delayed by one cycle.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module micadc_capture #(
   parameter int CKPCK = 2,
   parameter int LGDC  = 8
) (
   input wire              i_clk,
   input wire              i_reset_n,
   micadc_capture_if.master bus
);

   if (CKPCK < 1 || LGDC < 1) begin : g_param_check
      $error("micadc_capture: CKPCK and LGDC must both be at least 1");
   end

   localparam int             c_CW  = (CKPCK > 1) ? $clog2(CKPCK) : 1;
   localparam logic [c_CW-1:0] c_KM1 = c_CW'(CKPCK - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_SHIFT = 2'd2,
      S_QUIET = 2'd3
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [c_CW-1:0]   r_cnt;
   logic              r_phase;     // 0: SCK-low half of a bit, 1: SCK-high half
   logic [3:0]        r_bit;
   logic [15:0]       r_shift;
   logic              r_csn, r_sck, r_busy, r_overrun;
   logic              r_valid, r_err;
   logic [11:0]       r_data;

   logic              w_cnt_end;
   logic              w_start, w_sck_fall, w_sample, w_to_quiet, w_done;
   logic [11:0]       w_x;
   logic              w_err_raw;

   assign w_cnt_end = (r_cnt == c_KM1);
   // Offset binary to two's complement: flipping the MSB subtracts 2048.
   assign w_x       = {~r_shift[11], r_shift[10:0]};
   assign w_err_raw = |r_shift[15:12];

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_sck_fall  = 1'b0;
      w_sample    = 1'b0;
      w_to_quiet  = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.i_request) begin
               w_state_nxt = S_START;
               w_start     = 1'b1;
            end
         end
         S_START: begin
            if (w_cnt_end) begin
               w_state_nxt = S_SHIFT;
               w_sck_fall  = 1'b1;
            end
         end
         S_SHIFT: begin
            if (w_cnt_end) begin
               if (!r_phase) begin
                  w_sample = 1'b1;
               end else if (r_bit == 4'd15) begin
                  w_state_nxt = S_QUIET;
                  w_to_quiet  = 1'b1;
               end else begin
                  w_sck_fall = 1'b1;
               end
            end
         end
         S_QUIET: begin
            if (w_cnt_end) begin
               w_state_nxt = S_IDLE;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Disable wins over everything: abort to IDLE, no strobes.
      if (!bus.i_en) begin
         w_state_nxt = S_IDLE;
         w_start     = 1'b0;
         w_sck_fall  = 1'b0;
         w_sample    = 1'b0;
         w_to_quiet  = 1'b0;
         w_done      = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_phase   <= 1'b0;
         r_bit     <= 4'd0;
         r_shift   <= 16'd0;
         r_csn     <= 1'b1;
         r_sck     <= 1'b1;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // The counter times every K-cycle interval and restarts at each one.
         if (r_state == S_IDLE || w_cnt_end)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + c_CW'(1);
         if (w_start) begin
            r_csn   <= 1'b0;
            r_busy  <= 1'b1;
            r_bit   <= 4'd0;
            r_phase <= 1'b0;
         end
         if (w_sck_fall) begin
            r_sck   <= 1'b0;
            r_phase <= 1'b0;
            if (r_state == S_SHIFT)
               r_bit <= r_bit + 4'd1;
         end
         if (w_sample) begin
            r_sck   <= 1'b1;
            r_phase <= 1'b1;
            r_shift <= {r_shift[14:0], bus.i_miso};
         end
         if (w_to_quiet)
            r_csn <= 1'b1;
         if (w_done)
            r_busy <= 1'b0;
         if (!bus.i_en) begin
            r_csn  <= 1'b1;
            r_sck  <= 1'b1;
            r_busy <= 1'b0;
         end
         if (!bus.i_en)
            r_overrun <= 1'b0;
         else if (bus.i_request && r_busy)
            r_overrun <= 1'b1;
      end
   end

`ifdef MICADC_DCBLOCK_EN
   // Leaky integrator tracks the DC level scaled by 2^LGDC; the output is the
   // input minus that running estimate.
   localparam int c_AW = 12 + LGDC;

   logic                   r_pend, r_pend_err;
   logic signed [11:0]     r_x;
   logic signed [c_AW-1:0] r_acc;
   logic signed [c_AW-1:0] w_acc_sh;
   logic signed [11:0]     w_fb;
   logic signed [12:0]     w_y;
   logic [11:0]            w_y_sat;

   assign w_acc_sh = r_acc >>> LGDC;
   assign w_fb     = w_acc_sh[11:0];
   assign w_y      = 13'(r_x) - 13'(w_fb);
   assign w_y_sat  = (w_y[12] != w_y[11]) ? (w_y[12] ? 12'h800 : 12'h7FF) : w_y[11:0];
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_valid <= 1'b0;
         r_data  <= 12'd0;
         r_err   <= 1'b0;
`ifdef MICADC_DCBLOCK_EN
         r_pend     <= 1'b0;
         r_pend_err <= 1'b0;
         r_x        <= 12'sd0;
         r_acc      <= '0;
`endif
      end else begin
`ifdef MICADC_DCBLOCK_EN
         r_pend  <= w_done;
         r_valid <= r_pend & bus.i_en;
         if (w_done) begin
            r_x        <= w_x;
            r_pend_err <= w_err_raw;
         end
         if (!bus.i_en) begin
            r_acc <= '0;
         end else if (r_pend) begin
            r_data <= w_y_sat;
            r_err  <= r_pend_err;
            r_acc  <= r_acc + c_AW'(w_y);
         end
`else
         r_valid <= w_done;
         if (w_done) begin
            r_data <= w_x;
            r_err  <= w_err_raw;
         end
`endif
      end
   end

   assign bus.o_csn       = r_csn;
   assign bus.o_sck       = r_sck;
   assign bus.o_busy      = r_busy;
   assign bus.o_valid     = r_valid;
   assign bus.o_data      = r_data;
   assign bus.o_frame_err = r_err;
   assign bus.o_overrun   = r_overrun;

endmodule
`default_nettype wire
